// File: rtl/byte_packer.sv
// byte_packer: packs an 8-bit byte stream into 32-bit words.
//
// The first byte of a word lands in out[7:0], the last in out[31:24]. A word is
// emitted when four bytes have been collected or when a byte arrives with
// in_last set; unused upper lanes of a short word are filled with PAD_BYTE.
// The output register is a single-entry skid-free stage: a new byte is only
// accepted when the output register is empty or being drained this cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_        input byte
//   in_valid   in_ is valid
//   in_last    in_ is the final byte of a packet (qualified by in_valid)
//   in_ready   block can accept a byte this cycle
//   out        packed word
//   out_valid  out is valid
//   out_ready  downstream accepts the word this cycle
//   out_last   word ends a packet
//   out_nbytes number of valid bytes in out (1..4)
module byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [2:0]  out_nbytes
);

    logic [2:0][7:0] lanes_q, lanes_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     out_d;
    logic            valid_d;
    logic            last_d;
    logic [2:0]      nbytes_d;

    logic            byte_fire;
    logic            word_fire;
    logic            complete;
    logic [31:0]     new_word;

    // Ready depends only on the output register, never on the input side.
    assign in_ready  = !out_valid || out_ready;
    assign byte_fire = in_valid && in_ready;
    assign word_fire = out_valid && out_ready;
    assign complete  = byte_fire && ((cnt_q == 2'd3) || in_last);

    // Word formed from the lanes already assembled, the incoming byte in lane
    // cnt_q, and padding above it.
    always_comb begin
        new_word = {4{PAD_BYTE}};
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < cnt_q) begin
                new_word[8*i +: 8] = lanes_q[i];
            end else if (2'(i) == cnt_q) begin
                new_word[8*i +: 8] = in_;
            end else begin
                new_word[8*i +: 8] = PAD_BYTE;
            end
        end
        new_word[31:24] = (cnt_q == 2'd3) ? in_ : PAD_BYTE;
    end

    always_comb begin
        lanes_d  = lanes_q;
        cnt_d    = cnt_q;
        out_d    = out;
        valid_d  = out_valid;
        last_d   = out_last;
        nbytes_d = out_nbytes;

        if (complete) begin
            // Completing byte wins over a concurrent drain: valid stays high.
            out_d    = new_word;
            nbytes_d = {1'b0, cnt_q} + 3'd1;
            last_d   = in_last;
            valid_d  = 1'b1;
            cnt_d    = 2'd0;
        end else begin
            if (byte_fire) begin
                lanes_d[cnt_q] = in_;
                cnt_d          = cnt_q + 2'd1;
            end
            if (word_fire) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_q    <= '0;
            cnt_q      <= 2'd0;
            out        <= 32'h0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_nbytes <= 3'd0;
        end else begin
            lanes_q    <= lanes_d;
            cnt_q      <= cnt_d;
            out        <= out_d;
            out_valid  <= valid_d;
            out_last   <= last_d;
            out_nbytes <= nbytes_d;
        end
    end

endmodule
